add3: RTL and testbench
=======================

# add3

Registered BCD add-3 correction cell for the shift-and-add-3 (double-dabble) binary-to-BCD converter. Each cycle it takes one 4-bit BCD digit. If the digit is 5 or greater it adds 3; otherwise it passes the digit unchanged. The result is registered on the clock, and the converter array instantiates one cell per digit position per shift stage.

## Interface
- Parameters: none.
- Clocking: one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock; all state updates on posedge clk.
- rst_n  input  1  asynchronous active-low reset; clears all registers immediately when low.
- num  input  4  digit to correct (unsigned, 0–15 accepted).
- out  output  4  registered corrected digit.
- adj  output  1  registered flag; 1 when the captured num was ≥ 5, i.e. when 3 was added.

## Operation
- Combinational next-value:
  - num ≤ 4: next_out = num, next_adj = 0.
  - num ≥ 5: next_out = (num + 3) mod 16, next_adj = 1.
- Arithmetic is a 4-bit add; carry out of bit 3 is discarded, so values wrap.
- Full mapping for num 0..15 → out:
  - 0→0, 1→1, 2→2, 3→3, 4→4
  - 5→8, 6→9, 7→10, 8→11, 9→12
  - 10→13, 11→14, 12→15
  - 13→0, 14→1, 15→2
- Inputs 10–15 are not legal BCD. They are still defined by the wrap rule above: no X, no saturation.
- Comparison is num ≥ 5, unsigned. Boundary: 4 passes unchanged; 5 is adjusted.
- No enable: the cell captures every cycle.
- No internal state beyond the out/adj registers.

## Timing
- Latency: 1 cycle. A num sampled at posedge N appears on out/adj after posedge N; it is valid for the whole of cycle N+1.
- Throughput: one digit per cycle; back-to-back changes are tracked every cycle.
- Reset:
  - While rst_n = 0, out = 4'd0 and adj = 0, independent of clk.
  - Assertion takes effect asynchronously, mid-cycle included.
- Reset release:
  - Deassertion is synchronous to the design clock; the integrator provides the release synchronizer.
  - The first capture is at the first posedge with rst_n = 1.
- A reset asserted mid-stream discards the in-flight value. Nothing is replayed after release.
- Outputs are driven directly from flops, with no combinational path from num to out.
- num must be stable for setup/hold around posedge clk.

## Test plan
- Reset:
  - Hold rst_n = 0 with num = 9 and clock toggling → out = 0, adj = 0 throughout.
  - Release, then on the next edge → out = 12, adj = 1.
- Exhaustive sweep: num = 0..15, one value per cycle → out one cycle later follows the mapping above (0,1,2,3,4,8,9,10,11,12,13,14,15,0,1,2); adj = 0 for 0–4, 1 for 5–15.
- Threshold pair:
  - num = 4 → out = 4, adj = 0.
  - Next cycle num = 5 → out = 8, adj = 1.
- Wrap: num = 13, 14, 15 on consecutive cycles → out = 0, 1, 2 with adj = 1. No X on out.
- Async reset mid-stream:
  - Drive num = 7 and let out = 10.
  - Assert rst_n low between edges → out drops to 0 immediately, before the next posedge.
  - Release with num = 3 → out = 3, adj = 0.
- Hold: keep num = 6 for 5 cycles → out stays 9 and adj stays 1 every cycle, with no glitch.

Source files
------------

// File: rtl/add3.sv
// rtl/add3.sv - registered BCD add-3 correction cell for double-dabble conversion
module add3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] num,
    output logic [3:0] out,
    output logic       adj
);

    logic       next_adj;
    logic [3:0] next_out;

    // Correct digits of 5 or more by adding 3; the 4-bit sum wraps on overflow
    always_comb begin
        next_adj = (num >= 4'd5);
        next_out = num;
        if (next_adj) begin
            next_out = num + 4'd3;
        end
    end

    // Capture the corrected digit every cycle; reset clears outputs immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= 4'd0;
            adj <= 1'b0;
        end else begin
            out <= next_out;
            adj <= next_adj;
        end
    end

endmodule

// File: tb/tb_add3.sv
// tb/tb_add3.sv - directed self-checking bench for add3
module tb_add3;

    logic       clk;
    logic       rst_n;
    logic [3:0] num;
    logic [3:0] out;
    logic       adj;

    int n_cmp;
    int n_err;

    logic [3:0] exp_tab [0:15];

    add3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .num   (num),
        .out   (out),
        .adj   (adj)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a digit, clock it in, and settle just after the edge
    task automatic step(input logic [3:0] n);
        num = n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_tab[0]  = 4'd0;  exp_tab[1]  = 4'd1;  exp_tab[2]  = 4'd2;  exp_tab[3]  = 4'd3;
        exp_tab[4]  = 4'd4;  exp_tab[5]  = 4'd8;  exp_tab[6]  = 4'd9;  exp_tab[7]  = 4'd10;
        exp_tab[8]  = 4'd11; exp_tab[9]  = 4'd12; exp_tab[10] = 4'd13; exp_tab[11] = 4'd14;
        exp_tab[12] = 4'd15; exp_tab[13] = 4'd0;  exp_tab[14] = 4'd1;  exp_tab[15] = 4'd2;

        // Reset held with num = 9 and clock running
        rst_n = 1'b0;
        num   = 4'd9;
        #1;
        check("rst_out_t0", {4'd0, out}, 8'd0);
        check("rst_adj_t0", {7'd0, adj}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step(4'd9);
            check("rst_out_hold", {4'd0, out}, 8'd0);
            check("rst_adj_hold", {7'd0, adj}, 8'd0);
        end

        // Release between edges; first capture is the next posedge
        rst_n = 1'b1;
        step(4'd9);
        check("rel_out", {4'd0, out}, 8'd12);
        check("rel_adj", {7'd0, adj}, 8'd1);

        // Exhaustive sweep 0..15
        for (int i = 0; i < 16; i++) begin
            step(4'(i));
            check("sweep_out", {4'd0, out}, {4'd0, exp_tab[i]});
            check("sweep_adj", {7'd0, adj}, (i >= 5) ? 8'd1 : 8'd0);
        end

        // Threshold pair
        step(4'd4);
        check("thr4_out", {4'd0, out}, 8'd4);
        check("thr4_adj", {7'd0, adj}, 8'd0);
        step(4'd5);
        check("thr5_out", {4'd0, out}, 8'd8);
        check("thr5_adj", {7'd0, adj}, 8'd1);

        // Wrap region
        step(4'd13);
        check("wrap13_out", {4'd0, out}, 8'd0);
        check("wrap13_adj", {7'd0, adj}, 8'd1);
        step(4'd14);
        check("wrap14_out", {4'd0, out}, 8'd1);
        check("wrap14_adj", {7'd0, adj}, 8'd1);
        step(4'd15);
        check("wrap15_out", {4'd0, out}, 8'd2);
        check("wrap15_adj", {7'd0, adj}, 8'd1);

        // Async reset mid-stream
        step(4'd7);
        check("mid_pre_out", {4'd0, out}, 8'd10);
        check("mid_pre_adj", {7'd0, adj}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async_out", {4'd0, out}, 8'd0);
        check("mid_async_adj", {7'd0, adj}, 8'd0);
        @(posedge clk);
        #1;
        check("mid_held_out", {4'd0, out}, 8'd0);
        check("mid_held_adj", {7'd0, adj}, 8'd0);
        rst_n = 1'b1;
        step(4'd3);
        check("mid_rel_out", {4'd0, out}, 8'd3);
        check("mid_rel_adj", {7'd0, adj}, 8'd0);

        // Hold num = 6 for five cycles, also sampling mid-cycle
        for (int i = 0; i < 5; i++) begin
            step(4'd6);
            check("hold_out", {4'd0, out}, 8'd9);
            check("hold_adj", {7'd0, adj}, 8'd1);
            #4;
            check("hold_mid_out", {4'd0, out}, 8'd9);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
